// File: rtl/clk_reset_gen.sv
// Tick divider, slow clock and staged multi-channel reset sequencer with a
// synchronized, debounced manual reset request.
module clk_reset_gen #(
  parameter int CLK_DIV    = 120000,
  parameter int HOLD_TICKS = 4,
  parameter int NCH        = 2,
  parameter int STAGGER    = 1,
  parameter int DEB_TICKS  = 3
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           manual,
  output logic           tick,
  output logic           slow_clk,
  output logic [NCH-1:0] rst_out,
  output logic           busy,
  output logic [7:0]     rst_count
);
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int DEB_W   = $clog2(DEB_TICKS + 1);
  localparam int REL_MAX = (NCH - 1) * STAGGER;
  localparam int REL_W   = (REL_MAX < 1) ? 1 : $clog2(REL_MAX + 1);

  typedef enum logic [1:0] {PRE, HOLD, RELEASE, RUN} state_t;

  logic [DIV_W-1:0]  div_q, div_d;
  logic              div_last, div_pre;
  logic              tick_q, slow_q;
  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_q;
  logic              acc_q;
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [REL_W-1:0]  rel_q;
  logic              rel_done;
  logic [NCH-1:0]    rst_q, keep_first, keep_next;
  logic              busy_q;
  logic [7:0]        cnt_q;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_pre  = (div_q == DIV_W'(CLK_DIV - 2));
  assign div_d    = div_last ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      slow_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= '0;
      acc_q   <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= div_pre;
      slow_q  <= slow_q ^ div_pre;
      sync1_q <= manual;
      sync2_q <= sync1_q;
      acc_q   <= 1'b0;
      // Count saturates at DEB_TICKS, so only a low tick can re-arm acceptance.
      if (tick_q) begin
        if (sync2_q) begin
          if (deb_q != DEB_W'(DEB_TICKS)) deb_q <= deb_q + 1'b1;
          acc_q <= (deb_q == DEB_W'(DEB_TICKS - 1));
        end else begin
          deb_q <= '0;
        end
      end
    end
  end

  // Bit k stays asserted while its release tick k*STAGGER has not yet arrived.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_keep
    assign keep_first[gi] = (gi * STAGGER > 0);
    assign keep_next[gi]  = (gi * STAGGER > int'(rel_q) + 1);
  end

  assign rel_done = (int'(rel_q) + 1 >= REL_MAX);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= PRE;
      hold_q  <= '0;
      rel_q   <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (acc_q) begin
      state_q <= HOLD;
      hold_q  <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end else if (tick_q) begin
      case (state_q)
        PRE: begin
          state_q <= HOLD;
          hold_q  <= '0;
          rst_q   <= '1;
        end
        HOLD: begin
          if (!sync2_q) begin
            if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
              rel_q <= '0;
              rst_q <= keep_first;
              if (REL_MAX == 0) begin
                state_q <= RUN;
                busy_q  <= 1'b0;
              end else begin
                state_q <= RELEASE;
              end
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        RELEASE: begin
          rel_q <= rel_q + 1'b1;
          rst_q <= rst_q & keep_next;
          if (rel_done) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tick      = tick_q;
  assign slow_clk  = slow_q;
  assign rst_out   = rst_q;
  assign busy      = busy_q;
  assign rst_count = cnt_q;
endmodule

// File: tb/tb_clk_reset_gen.sv
// Bench for clk_reset_gen: random manual episodes checked every cycle against
// an edge-counting reference model, plus fixed-value anchors for key points.
module tb_clk_reset_gen;
  localparam int CLK_DIV    = 4;
  localparam int HOLD_TICKS = 2;
  localparam int NCH        = 3;
  localparam int STAGGER    = 1;
  localparam int DEB_TICKS  = 2;

  localparam int M_PRE  = 0;
  localparam int M_HOLD = 1;
  localparam int M_REL  = 2;
  localparam int M_RUN  = 3;

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           manual = 1'b0;
  logic           tick;
  logic           slow_clk;
  logic [NCH-1:0] rst_out;
  logic           busy;
  logic [7:0]     rst_count;

  clk_reset_gen #(
    .CLK_DIV(CLK_DIV), .HOLD_TICKS(HOLD_TICKS), .NCH(NCH),
    .STAGGER(STAGGER), .DEB_TICKS(DEB_TICKS)
  ) dut (
    .clk(clk), .n_rst(n_rst), .manual(manual), .tick(tick),
    .slow_clk(slow_clk), .rst_out(rst_out), .busy(busy), .rst_count(rst_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edges since reset release, sequence phase and progress.
  int e, mode, hold_done, rel_t, deb, cnt;
  bit pend;
  bit man_q[$];

  task automatic m_reset();
    e = 0; mode = M_PRE; hold_done = 0; rel_t = 0; deb = 0; cnt = 0; pend = 0;
    man_q = '{1'b0, 1'b0};
  endtask

  task automatic m_edge();
    bit used;
    e++;
    used = man_q[0];          // manual as sampled two edges ago
    man_q.push_back(manual);
    void'(man_q.pop_front());
    if (pend) begin
      mode = M_HOLD; hold_done = 0; pend = 0;
      if (cnt < 255) cnt++;
    end else if (e % CLK_DIV == 0) begin
      if (used) begin
        if (deb == DEB_TICKS - 1) pend = 1;
        if (deb < DEB_TICKS) deb++;
      end else begin
        deb = 0;
      end
      case (mode)
        M_PRE: begin mode = M_HOLD; hold_done = 0; end
        M_HOLD: if (!used) begin
          hold_done++;
          if (hold_done == HOLD_TICKS) begin mode = M_REL; rel_t = 0; end
        end
        M_REL: rel_t++;
        default: ;
      endcase
      if (mode == M_REL && rel_t >= (NCH - 1) * STAGGER) mode = M_RUN;
    end
  endtask

  function automatic logic [NCH-1:0] exp_rst();
    logic [NCH-1:0] r;
    r = '0;
    for (int k = 0; k < NCH; k++)
      if (mode == M_HOLD) r[k] = 1'b1;
      else if (mode == M_REL) r[k] = (k * STAGGER > rel_t);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    m_edge();
    #2;
    check("tick", tick, (e % CLK_DIV == CLK_DIV - 1));
    check("slow_clk", slow_clk, ((e + 1) / CLK_DIV) % 2);
    check("rst_out", rst_out, exp_rst());
    check("busy", busy, (mode != M_RUN));
    check("rst_count", rst_count, cnt);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tick"}, tick, 0);
    check({tag, "_slow"}, slow_clk, 0);
    check({tag, "_rst"}, rst_out, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_cnt"}, rst_count, 0);
  endtask

  // Power-up sequence with manual idle: fixed rst_out values at tick 1,3,4,5.
  task automatic seq_anchor(input string tag);
    steps(4);
    check({tag, "_t1"}, rst_out, 3'b111);
    steps(8);
    check({tag, "_t3"}, rst_out, 3'b110);
    steps(4);
    check({tag, "_t4"}, rst_out, 3'b100);
    steps(4);
    check({tag, "_t5"}, rst_out, 3'b000);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("por");
    n_rst = 1'b1;
    m_reset();
    seq_anchor("seq");

    // Single high tick is not a request.
    manual = 1'b1; steps(4);
    manual = 1'b0; steps(20);
    check("short_rst", rst_out, 0);
    check("short_cnt", rst_count, 0);

    // Held request: accepted, HOLD extends while manual stays high.
    manual = 1'b1; steps(12);
    check("req_rst", rst_out, 3'b111);
    check("req_cnt", rst_count, 1);
    manual = 1'b0; steps(40);

    for (int i = 0; i < 60; i++) begin
      manual = 1'b1; steps($urandom_range(1, 16));
      manual = 1'b0; steps($urandom_range(1, 40));
    end

    // Asynchronous reset while in HOLD.
    steps(40);
    manual = 1'b1; steps(12);
    manual = 1'b0; steps(2);
    check("hold_pre_rst", rst_out, 3'b111);
    n_rst = 1'b0;
    #1;
    check_reset_vals("async");
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("async_held");
    n_rst = 1'b1;
    m_reset();
    seq_anchor("reseq");

    // Saturation of the request counter.
    for (int i = 0; i < 258; i++) begin
      manual = 1'b1; steps(12);
      manual = 1'b0; steps(8);
    end
    check("sat_cnt", rst_count, 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
